// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect and decode handshake.
// The master side is the fetch unit; the slave side is the memory/execute/decode environment.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues in-order word fetches under a credit limit,
// buffers returned words with their addresses, and flushes on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;
  typedef logic [IW-1:0] idx_t;

  localparam sum_t DEPTH_S = sum_t'(DEPTH);

  function automatic idx_t inc(input idx_t p);
    return (p == idx_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q [DEPTH];
  logic [31:0] ipc_q   [DEPTH];
  logic [31:0] pend_q  [DEPTH];
  idx_t        rd_q, rd_d, wr_q, wr_d;
  idx_t        prd_q, prd_d, pwr_q, pwr_d;
  cnt_t        count_q, count_d;
  cnt_t        outst_q, outst_d;
  cnt_t        drop_q, drop_d;

  logic        redir, if_valid_w, pop, req_valid_w, req_fire, rsp, keep;
  sum_t        credit;

  assign redir       = bus.redirect_valid;
  assign rsp         = bus.imem_rsp_valid;
  assign if_valid_w  = rst_n && (count_q != '0) && !redir;
  assign pop         = if_valid_w && bus.if_ready;
  assign credit      = sum_t'(outst_q) + sum_t'(count_q) - sum_t'(pop);
  assign req_valid_w = rst_n && !redir && (credit < DEPTH_S);
  assign req_fire    = req_valid_w && bus.imem_req_ready;
  assign keep        = rsp && !redir && (drop_q == '0);

  assign bus.imem_req_valid = req_valid_w;
  assign bus.imem_req_addr  = rst_n ? pc_q : '0;
  assign bus.if_valid       = if_valid_w;
  assign bus.if_instr       = rst_n ? instr_q[rd_q] : '0;
  assign bus.if_pc          = rst_n ? ipc_q[rd_q] : '0;

  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q + cnt_t'(req_fire) - cnt_t'(rsp);
    drop_d  = drop_q;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    prd_d   = rsp ? inc(prd_q) : prd_q;
    pwr_d   = req_fire ? inc(pwr_q) : pwr_q;

    if (redir) begin
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d  = outst_q - cnt_t'(rsp);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (rsp && (drop_q != '0)) drop_d = drop_q - 1'b1;
      count_d = count_q + cnt_t'(keep) - cnt_t'(pop);
      if (keep) wr_d = inc(wr_q);
      if (pop)  rd_d = inc(rd_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      prd_q   <= '0;
      pwr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
        pend_q[i]  <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      prd_q   <= prd_d;
      pwr_q   <= pwr_d;
      if (req_fire) pend_q[pwr_q] <= pc_q;
      if (keep) begin
        instr_q[wr_q] <= bus.imem_rsp_data;
        ipc_q[wr_q]   <= pend_q[prd_q];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap and mid-stream reset,
// against a fixed-latency in-order instruction memory model.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: requests seen mid-cycle, answered exactly lat cycles later.
  typedef struct { int unsigned due; logic [31:0] addr; } mreq_t;
  mreq_t       mq[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end
      if (bus.imem_req_valid && bus.imem_req_ready)
        mq.push_back('{cyc + lat, bus.imem_req_addr});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_if(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, bus.if_valid}, 32'd1);
    chk({tag, "_pc"}, bus.if_pc, pc);
    chk({tag, "_instr"}, bus.if_instr, mem_word(pc));
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    chk({tag, "_rv"}, {31'd0, bus.imem_req_valid}, 32'd1);
    chk({tag, "_addr"}, bus.imem_req_addr, addr);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ifv", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_rqv", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_addr", bus.imem_req_addr, 32'd0);
    chk("rst_ifpc", bus.if_pc, 32'd0);
    chk("rst_ifin", bus.if_instr, 32'd0);
    next_cycle();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b1;
    #2;
    chk("por_ifv", {31'd0, bus.if_valid}, 32'd0);
    chk("por_rqv", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("por_addr", bus.imem_req_addr, 32'd0);
    chk("por_ifpc", bus.if_pc, 32'd0);
    chk("por_ifin", bus.if_instr, 32'd0);
    next_cycle();
    next_cycle();

    // Stream at L=1: one request per cycle, words reach decode two cycles after issue.
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin next_cycle(); #1; end
      expect_req($sformatf("str%0d", k), 32'h100 + 32'(4 * k));
      if (k >= 2) expect_if($sformatf("str%0d", k), 32'h100 + 32'(4 * (k - 2)));
      else chk($sformatf("str%0d_nv", k), {31'd0, bus.if_valid}, 32'd0);
    end

    // Backpressure: FIFO fills to two, request withdrawn, head held.
    for (int j = 0; j < 5; j++) begin
      next_cycle();
      bus.if_ready = 1'b0;
      #1;
      chk($sformatf("bp%0d_rv", j), {31'd0, bus.imem_req_valid}, 32'd0);
      expect_if($sformatf("bp%0d", j), 32'h118);
    end
    for (int j = 0; j < 4; j++) begin
      next_cycle();
      bus.if_ready = 1'b1;
      #1;
      if (j == 0) expect_req("res_req", 32'h120);
      expect_if($sformatf("res%0d", j), 32'h118 + 32'(4 * j));
    end

    // Fill the FIFO again, then reset mid-cycle.
    next_cycle();
    bus.if_ready = 1'b0;
    next_cycle();
    #1;
    chk("full_rv", {31'd0, bus.imem_req_valid}, 32'd0);
    expect_if("full", 32'h128);
    #2;
    bus.if_ready = 1'b1;
    lat = 3;
    pulse_reset();

    // Redirect with two requests in flight at L=3.
    rst_n = 1'b1;
    #1;
    expect_req("rr0", 32'h100);
    next_cycle(); #1;
    expect_req("rr1", 32'h104);
    next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2000;
    #1;
    chk("rr2_rv", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rr2_ifv", {31'd0, bus.if_valid}, 32'd0);
    next_cycle();
    bus.redirect_valid = 1'b0;
    #1;
    chk("rr3_rv", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rr3_ifv", {31'd0, bus.if_valid}, 32'd0);
    next_cycle(); #1;
    expect_req("rr4", 32'h2000);
    for (int j = 5; j < 8; j++) begin
      next_cycle(); #1;
      chk($sformatf("rr%0d_ifv", j), {31'd0, bus.if_valid}, 32'd0);
    end
    next_cycle(); #1;
    expect_if("rr8", 32'h2000);
    next_cycle(); #1;
    expect_if("rr9", 32'h2004);
    #1;
    pulse_reset();

    // Misaligned redirect coinciding with a response and a would-be pop.
    rst_n = 1'b1;
    #1;
    for (int j = 1; j < 4; j++) begin
      next_cycle();
    end
    next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_3003;
    #1;
    chk("mr_rsp", {31'd0, bus.imem_rsp_valid}, 32'd1);
    chk("mr_ifv", {31'd0, bus.if_valid}, 32'd0);
    chk("mr_rv", {31'd0, bus.imem_req_valid}, 32'd0);
    next_cycle();
    bus.redirect_valid = 1'b0;
    #1;
    expect_req("mr5", 32'h3000);
    chk("mr5_ifv", {31'd0, bus.if_valid}, 32'd0);
    for (int j = 6; j < 9; j++) begin
      next_cycle(); #1;
      chk($sformatf("mr%0d_ifv", j), {31'd0, bus.if_valid}, 32'd0);
    end
    next_cycle(); #1;
    expect_if("mr9", 32'h3000);
    next_cycle(); #1;
    expect_if("mr10", 32'h3004);
    #1;
    lat = 1;
    pulse_reset();

    // PC wrap, with the first target request held by memory backpressure.
    rst_n              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    #1;
    chk("wr0_rv", {31'd0, bus.imem_req_valid}, 32'd0);
    next_cycle();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    #1;
    expect_req("wr1", 32'hFFFF_FFFC);
    next_cycle(); #1;
    expect_req("wr2", 32'hFFFF_FFFC);
    next_cycle();
    bus.imem_req_ready = 1'b1;
    #1;
    expect_req("wr3", 32'hFFFF_FFFC);
    next_cycle(); #1;
    expect_req("wr4", 32'h0000_0000);
    next_cycle(); #1;
    expect_if("wr5", 32'hFFFF_FFFC);
    next_cycle(); #1;
    expect_if("wr6", 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 3-stage RV32I pipeline. It sits directly upstream of the decoder. It owns the PC and issues in-order word requests to instruction memory. Returned words go into a small FIFO, and each is presented to the decode stage as an {instr, pc} pair with a valid/ready handshake. Redirects from branch/jump resolution flush the FIFO and discard stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: PC of the first fetch after reset.
- `DEPTH`, 2: instruction FIFO entries (≥2). Also the cap on in-flight + buffered words.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts request (handshake = valid & ready).
- `imem_req_addr`  out  32  word-aligned fetch address (= PC register).
- `imem_rsp_valid`  in  1  response strobe. Responses are in order, one per accepted request, latency ≥1 cycle, and cannot be stalled.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  control-flow change from execute (taken branch, JAL, JALR).
- `redirect_pc`  in  32  new fetch PC. Bits [1:0] are ignored (treated as 0).
- `if_valid`  out  1  `if_instr`/`if_pc` valid for decode.
- `if_ready`  in  1  decode accepts (pop = if_valid & if_ready).
- `if_instr`  out  32  instruction word for decoder.
- `if_pc`  out  32  address of `if_instr`.

## Operation
- **State:**
  - `pc`: 32 bits.
  - FIFO of DEPTH × {instr, pc}, with `count`.
  - `pend_pc` FIFO of DEPTH × 32 recording the addresses of accepted requests.
  - `outstanding` (total in-flight): `$clog2(DEPTH+1)` bits.
  - `drop` (stale in-flight): same width.
- **Issue:**
  - `imem_req_valid = !redirect_valid && (outstanding + count - pop) < DEPTH`.
  - On handshake: `pc <= pc + 4` (wraps modulo 2^32), `outstanding++`, and the address is pushed to `pend_pc`.
- **Response:**
  - On `imem_rsp_valid`, `outstanding--` and `pend_pc` is popped.
  - If `drop > 0`: `drop--` and the word is discarded.
  - Otherwise {`imem_rsp_data`, popped pend_pc} is pushed to the FIFO. It cannot overflow by the credit rule.
- **Output:** `if_valid = (count != 0) && !redirect_valid`; `if_instr`/`if_pc` = FIFO head. Pop when `if_valid & if_ready`.
- **Redirect** (`redirect_valid` = 1), with priority over everything else:
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - FIFO and `count` cleared.
  - No request is issued and no pop occurs that cycle.
  - A response arriving the same cycle is discarded.
  - `drop <=` number of requests still in flight after this cycle (`outstanding` minus this cycle's response). `outstanding` keeps counting them.
  - A redirect while `drop > 0` recomputes `drop` the same way.
- Simultaneous response push and pop in the same cycle are both performed; `count` is unchanged.
- The decoder consumes `if_instr` directly. No pre-decoding is done here.

## Timing
- **Reset (asynchronous, immediate):**
  - `pc = RESET_PC`; `count`, `outstanding`, `drop` = 0.
  - `imem_req_valid = 0`, `if_valid = 0`; `if_instr`, `if_pc`, `imem_req_addr` = 0 while `rst_n` is low.
- First request with `imem_req_addr = RESET_PC` is asserted in the first cycle after `rst_n` deasserts.
- **Latency:** request accepted in cycle T, response at T+L, `if_valid` at T+L+1 (the FIFO is registered, with no bypass).
- **Throughput:** one instruction per cycle sustained with L=1, `DEPTH=2`, and `if_ready` held high.
- **Redirect penalty:** new-target request in cycle R+1. Its word reaches decode at R+2+L at the earliest, after stale responses drain.
- **Reset mid-operation:** all in-flight state is lost. The memory model must also be reset, since no late responses are tolerated after reset.
- **`imem_req_valid` stability:** once asserted without `redirect_valid`, it stays high with the same address until accepted. The one exception is that a redirect may withdraw it.

## Test plan
- **Reset and stream:** `RESET_PC`=0x100, memory L=1, `if_ready`=1 → requests 0x100, 0x104, 0x108… on consecutive cycles. `if_pc` = 0x100 at cycle 3 after reset, then +4 every cycle, with `if_instr` matching memory.
- **Backpressure:** `if_ready`=0 for 5 cycles while streaming → `count` saturates at 2, `imem_req_valid`=0. Resume → no word lost or duplicated, PCs in order.
- **Redirect with in-flight:** L=3, redirect to 0x2000 while 2 requests are in flight → both stale responses discarded. The next `if_pc` is 0x2000 with the correct word, and 0x2004 follows.
- **Redirect misaligned and same-cycle events:** `redirect_pc`=0x3003 asserted in the same cycle as a response and an `if_ready` pop → `if_valid`=0 that cycle, next `imem_req_addr`=0x3000, FIFO empty.
- **PC wrap:** redirect to 0xFFFF_FFFC → next request address 0x0000_0000.
- **Reset mid-stream:** `rst_n` pulsed low mid-cycle while `count`=2 → `if_valid` and `imem_req_valid` drop immediately. Fetch restarts at `RESET_PC`.
